// File: rtl/hxdp_pkg.sv
// rtl/hxdp_pkg.sv - shared hXDP page map, rx FSM states and rx descriptor type
package hxdp_pkg;

  localparam int unsigned QUEUES_PAGE = 0;
  localparam int unsigned XDP_MD_PAGE = 1;
  localparam int unsigned STACK_PAGE  = 2;
  localparam int unsigned MAPS_PAGE   = 3;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_WRITE,
    RX_DROP
  } rx_state_e;

  // Slot field is sized for the largest supported ring (256 slots).
  typedef struct packed {
    logic [7:0]  slot;
    logic [15:0] len;
  } rx_desc_t;

endpackage

// File: rtl/hxdp_rx_len_count.sv
// rtl/hxdp_rx_len_count.sv - tkeep popcount with per-frame registered byte accumulator
module hxdp_rx_len_count
  import hxdp_pkg::*;
#(
  parameter int KEEP_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              beat_i,
  input  logic              start_i,
  input  logic [KEEP_W-1:0] keep_i,
  output logic [15:0]       len_o
);

  logic [15:0] cnt;
  logic [15:0] acc_q;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      cnt = cnt + 16'(keep_i[i]);
    end
  end

  // The first beat of a frame restarts the sum, so no separate clear is needed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (beat_i) begin
      acc_q <= start_i ? cnt : acc_q + cnt;
    end
  end

  assign len_o = acc_q;

endmodule

// File: rtl/hxdp_rx_frame_buffer.sv
// rtl/hxdp_rx_frame_buffer.sv - AXIS RX ingress into slotted packet memory with descriptor/release ring
// Define HXDP_RX_FCS_DROP_EN to discard frames whose tlast beat carries tuser[0] (bad FCS).
module hxdp_rx_frame_buffer
  import hxdp_pkg::*;
#(
  parameter int AXIS_SYNC_DATA_WIDTH    = 512,
  parameter int AXIS_SYNC_KEEP_WIDTH    = AXIS_SYNC_DATA_WIDTH / 8,
  parameter int AXIS_SYNC_RX_USER_WIDTH = 1,
  parameter int SLOT_COUNT              = 4,
  parameter int SLOT_BYTES              = 2048,
  parameter int MEM_ADDR_WIDTH          = $clog2(SLOT_COUNT * SLOT_BYTES / (AXIS_SYNC_DATA_WIDTH / 8))
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               s_axis_tvalid,
  input  logic [AXIS_SYNC_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [AXIS_SYNC_KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic                               s_axis_tlast,
  input  logic [AXIS_SYNC_RX_USER_WIDTH-1:0] s_axis_tuser,
  output logic                               s_axis_tready,
  output logic                               mem_wr_en,
  output logic [MEM_ADDR_WIDTH-1:0]          mem_wr_addr,
  output logic [AXIS_SYNC_DATA_WIDTH-1:0]    mem_wr_data,
  output logic [AXIS_SYNC_KEEP_WIDTH-1:0]    mem_wr_strb,
  output logic                               desc_valid,
  input  logic                               desc_ready,
  output logic [$clog2(SLOT_COUNT)-1:0]      desc_slot,
  output logic [15:0]                        desc_len,
  input  logic                               rel_valid,
  input  logic [$clog2(SLOT_COUNT)-1:0]      rel_slot,
  output logic [31:0]                        stat_drop_count,
  output logic                               stat_rel_err
);

  localparam int SLOT_BEATS = SLOT_BYTES / (AXIS_SYNC_DATA_WIDTH / 8);
  localparam int SW         = $clog2(SLOT_COUNT);
  localparam int PW         = SW + 1;
  localparam int BW         = $clog2(SLOT_BEATS) + 1;

  rx_state_e                       state_q, state_d;
  logic [PW-1:0]                   fill_q, fill_d;
  logic [PW-1:0]                   wr_q, desc_q, rel_q;
  logic [BW-1:0]                   idx_q, idx_d;
  logic [31:0]                     drop_q, drop_d;
  logic                            wr_en_q, wr_en_d;
  logic [MEM_ADDR_WIDTH-1:0]       wr_addr_q, wr_addr_d;
  logic [AXIS_SYNC_DATA_WIDTH-1:0] wr_data_q;
  logic [AXIS_SYNC_KEEP_WIDTH-1:0] wr_strb_q;
  logic                            commit_q, commit_d;
  logic                            ready_q, rel_err_q;
  logic [15:0]                     len_q [SLOT_COUNT];
  logic [15:0]                     frame_len;
  logic [MEM_ADDR_WIDTH-1:0]       slot_base;
  logic                            accept, start, full, fcs_bad, frame_ok, frame_bad;

  assign accept    = s_axis_tvalid && ready_q;
  // fill_q runs ahead of wr_q by the one-cycle commit delay, so it is the true occupancy.
  assign full      = (fill_q - rel_q) == PW'(SLOT_COUNT);
  assign slot_base = MEM_ADDR_WIDTH'(fill_q[SW-1:0]) * MEM_ADDR_WIDTH'(SLOT_BEATS);

`ifdef HXDP_RX_FCS_DROP_EN
  assign fcs_bad = s_axis_tuser[0];
`else
  logic unused_tuser;
  assign fcs_bad     = 1'b0;
  assign unused_tuser = ^s_axis_tuser;
`endif

  hxdp_rx_len_count #(
    .KEEP_W (AXIS_SYNC_KEEP_WIDTH)
  ) u_len_count (
    .clk_i   (clk),
    .rst_ni  (reset),
    .beat_i  (accept),
    .start_i (start),
    .keep_i  (s_axis_tkeep),
    .len_o   (frame_len)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    fill_d    = fill_q;
    drop_d    = drop_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    commit_d  = 1'b0;
    start     = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if (accept) begin
      unique case (state_q)
        RX_IDLE: begin
          start = 1'b1;
          if (full) begin
            frame_bad = s_axis_tlast;
            if (!s_axis_tlast) state_d = RX_DROP;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = slot_base;
            idx_d     = BW'(1);
            frame_ok  = s_axis_tlast;
            if (!s_axis_tlast) state_d = RX_WRITE;
          end
        end
        RX_WRITE: begin
          if (idx_q == BW'(SLOT_BEATS)) begin
            frame_bad = s_axis_tlast;
            state_d   = s_axis_tlast ? RX_IDLE : RX_DROP;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = slot_base + MEM_ADDR_WIDTH'(idx_q);
            idx_d     = idx_q + BW'(1);
            frame_ok  = s_axis_tlast;
            if (s_axis_tlast) state_d = RX_IDLE;
          end
        end
        RX_DROP: begin
          if (s_axis_tlast) begin
            frame_bad = 1'b1;
            state_d   = RX_IDLE;
          end
        end
        default: state_d = RX_IDLE;
      endcase
      if (frame_ok && !fcs_bad) begin
        commit_d = 1'b1;
        fill_d   = fill_q + PW'(1);
      end
      if (frame_bad || (frame_ok && fcs_bad)) begin
        drop_d = (&drop_q) ? drop_q : drop_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RX_IDLE;
      idx_q     <= '0;
      fill_q    <= '0;
      wr_q      <= '0;
      desc_q    <= '0;
      rel_q     <= '0;
      drop_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      commit_q  <= 1'b0;
      ready_q   <= 1'b0;
      rel_err_q <= 1'b0;
      for (int i = 0; i < SLOT_COUNT; i++) len_q[i] <= '0;
    end else begin
      ready_q   <= 1'b1;
      state_q   <= state_d;
      idx_q     <= idx_d;
      fill_q    <= fill_d;
      drop_q    <= drop_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      commit_q  <= commit_d;
      if (accept) begin
        wr_data_q <= s_axis_tdata;
        wr_strb_q <= s_axis_tkeep;
      end
      // Publishing one cycle late keeps the descriptor behind its last memory write.
      if (commit_q) begin
        len_q[wr_q[SW-1:0]] <= frame_len;
        wr_q                <= wr_q + PW'(1);
      end
      if (desc_valid && desc_ready) desc_q <= desc_q + PW'(1);
      if (rel_valid) begin
        if (rel_slot == rel_q[SW-1:0] && rel_q != desc_q) rel_q <= rel_q + PW'(1);
        else rel_err_q <= 1'b1;
      end
    end
  end

  assign s_axis_tready   = ready_q;
  assign mem_wr_en       = wr_en_q;
  assign mem_wr_addr     = wr_addr_q;
  assign mem_wr_data     = wr_data_q;
  assign mem_wr_strb     = wr_strb_q;
  assign desc_valid      = desc_q != wr_q;
  assign desc_slot       = desc_q[SW-1:0];
  assign desc_len        = len_q[desc_q[SW-1:0]];
  assign stat_drop_count = drop_q;
  assign stat_rel_err    = rel_err_q;

endmodule

// File: tb/tb_hxdp_rx_frame_buffer.sv
// tb/tb_hxdp_rx_frame_buffer.sv - scoreboard bench for hxdp_rx_frame_buffer
module tb_hxdp_rx_frame_buffer;
  import hxdp_pkg::*;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int SC = 4;
  localparam int SB = 2048;
  localparam int SLOT_BEATS = SB / KW;
  localparam int AW = 7;
`ifdef HXDP_RX_FCS_DROP_EN
  localparam bit FCS_EN = 1'b1;
`else
  localparam bit FCS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tlast = 1'b0;
  logic [0:0]    s_axis_tuser = '0;
  logic          s_axis_tready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [KW-1:0] mem_wr_strb;
  logic          desc_valid;
  logic          desc_ready = 1'b0;
  logic [1:0]    desc_slot;
  logic [15:0]   desc_len;
  logic          rel_valid = 1'b0;
  logic [1:0]    rel_slot = '0;
  logic [31:0]   stat_drop_count;
  logic          stat_rel_err;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [KW-1:0] strb;
  } wr_t;

  wr_t      wq[$];
  rx_desc_t dq[$];
  int tests_run = 0;
  int tests_failed = 0;
  int committed = 0, released = 0, desc_seen = 0, exp_drops = 0;
  bit exp_rel_err = 1'b0;
  int ready_mode = 0;

  hxdp_rx_frame_buffer #(
    .AXIS_SYNC_DATA_WIDTH    (DW),
    .AXIS_SYNC_KEEP_WIDTH    (KW),
    .AXIS_SYNC_RX_USER_WIDTH (1),
    .SLOT_COUNT              (SC),
    .SLOT_BYTES              (SB),
    .MEM_ADDR_WIDTH          (AW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tuser    (s_axis_tuser),
    .s_axis_tready   (s_axis_tready),
    .mem_wr_en       (mem_wr_en),
    .mem_wr_addr     (mem_wr_addr),
    .mem_wr_data     (mem_wr_data),
    .mem_wr_strb     (mem_wr_strb),
    .desc_valid      (desc_valid),
    .desc_ready      (desc_ready),
    .desc_slot       (desc_slot),
    .desc_len        (desc_len),
    .rel_valid       (rel_valid),
    .rel_slot        (rel_slot),
    .stat_drop_count (stat_drop_count),
    .stat_rel_err    (stat_rel_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: %s", name, msg);
  endtask

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       desc_ready = 1'b0;
      1:       desc_ready = 1'b1;
      default: desc_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every write and every descriptor handshake must match the head of its queue.
  always @(negedge clk) begin
    wr_t      e;
    rx_desc_t d;
    if (reset) begin
      if (mem_wr_en) begin
        if (wq.size() == 0) fail("unexpected_write", $sformatf("addr %0d with nothing expected", mem_wr_addr));
        else begin
          e = wq.pop_front();
          check("wr_addr", DW'(mem_wr_addr), DW'(e.addr));
          check("wr_data", mem_wr_data, e.data);
          check("wr_strb", DW'(mem_wr_strb), DW'(e.strb));
        end
      end
      if (desc_valid && desc_ready) begin
        if (dq.size() == 0) fail("unexpected_desc", $sformatf("slot %0d len %0d", desc_slot, desc_len));
        else begin
          d = dq.pop_front();
          check("desc_slot", DW'(desc_slot), DW'(d.slot));
          check("desc_len", DW'(desc_len), DW'(d.len));
          desc_seen++;
        end
      end
    end
  end

  // Reference model: slot = committed frames mod SC, drop when SC frames are held or oversize.
  task automatic send_frame(input int nbeats, input int last_bytes, input bit bad);
    int            slot;
    bit            dropping;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    wr_t           e;
    rx_desc_t      dsc;
    dropping = (committed - released) >= SC;
    slot = committed % SC;
    for (int b = 0; b < nbeats; b++) begin
      for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
      k = '1;
      if (b == nbeats - 1) begin
        k = '0;
        for (int i = 0; i < last_bytes; i++) k[i] = 1'b1;
      end
      if (b >= SLOT_BEATS) dropping = 1'b1;
      if (!dropping) begin
        e.addr = AW'(slot * SLOT_BEATS + b);
        e.data = d;
        e.strb = k;
        wq.push_back(e);
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = (b == nbeats - 1);
      s_axis_tuser  = 1'((b == nbeats - 1) && bad);
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
    if (dropping || (bad && FCS_EN)) exp_drops++;
    else begin
      dsc.slot = 8'(slot);
      dsc.len  = 16'((nbeats - 1) * KW + last_bytes);
      dq.push_back(dsc);
      committed++;
    end
  endtask

  task automatic do_release(input int slot);
    bit ok;
    ok = (slot == released % SC) && (released < desc_seen);
    rel_valid = 1'b1;
    rel_slot  = 2'(slot);
    @(posedge clk); #1;
    rel_valid = 1'b0;
    if (ok) released++;
    else exp_rel_err = 1'b1;
  endtask

  task automatic check_stats(input string tag);
    @(negedge clk);
    check({tag, "_drop_count"}, DW'(stat_drop_count), DW'(exp_drops));
    check({tag, "_rel_err"}, DW'(stat_rel_err), DW'(exp_rel_err));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    ready_mode = 1;
    while ((wq.size() != 0 || dq.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_drained"}, DW'(wq.size() + dq.size()), '0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_tready", DW'(s_axis_tready), '0);
    check("rst_desc_valid", DW'(desc_valid), '0);
    check("rst_mem_wr_en", DW'(mem_wr_en), '0);
    check("rst_drop_count", DW'(stat_drop_count), '0);
    check("rst_rel_err", DW'(stat_rel_err), '0);
    wq.delete();
    dq.delete();
    committed = 0; released = 0; desc_seen = 0; exp_drops = 0; exp_rel_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("tready_after_reset", DW'(s_axis_tready), DW'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nb, lb;
    ready_mode = 1;
    do_reset();

    // 1: single 64 B beat, descriptor two cycles after tlast
    send_frame(1, 64, 1'b0);
    @(negedge clk);
    check("t1_desc_early", DW'(desc_valid), '0);
    @(negedge clk);
    check("t1_desc_valid", DW'(desc_valid), DW'(1));
    check("t1_desc_slot", DW'(desc_slot), '0);
    check("t1_desc_len", DW'(desc_len), DW'(64));
    @(posedge clk); #1;

    // 2: 130 B in three beats into slot 1
    send_frame(3, 2, 1'b0);
    drain("t2");

    // 3: ring full drop, then release and reuse of slot 0
    do_reset();
    for (int i = 0; i < 4; i++) send_frame($urandom_range(1, 3), 64, 1'b0);
    send_frame(2, 64, 1'b0);
    check_stats("t3_full");
    drain("t3a");
    do_release(0);
    send_frame(1, 64, 1'b0);
    drain("t3b");

    // 4: oversize frame dropped, next frame reuses slot base
    do_reset();
    send_frame(33, 64, 1'b0);
    check_stats("t4_oversize");
    send_frame(2, 10, 1'b0);
    drain("t4");

    // 5: held descriptors drain back-to-back; out-of-order release flagged
    do_reset();
    ready_mode = 0;
    for (int i = 0; i < 3; i++) send_frame($urandom_range(1, 2), $urandom_range(1, 64), 1'b0);
    repeat (3) @(posedge clk);
    #1 ready_mode = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_burst_valid", DW'(desc_valid), DW'(1));
      check("t5_burst_slot", DW'(desc_slot), DW'(k));
    end
    @(posedge clk); #1;
    do_release(2);
    check_stats("t5_bad_rel");
    do_release(0);
    do_release(1);
    do_release(2);
    drain("t5");

    // 6: bad FCS flag on tlast, zero-length tail on the following frame
    do_reset();
    send_frame(2, 20, 1'b1);
    check_stats("t6_fcs");
    send_frame(2, 0, 1'b0);
    drain("t6");

    // random traffic with random backpressure and releases
    do_reset();
    ready_mode = 2;
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 9) < 3) begin
        if (released < desc_seen) do_release(($urandom_range(0, 7) == 0) ? (released + 1) % SC : released % SC);
      end else begin
        nb = ($urandom_range(0, 9) == 0) ? $urandom_range(32, 34) : $urandom_range(1, 6);
        lb = $urandom_range(0, 64);
        send_frame(nb, lb, $urandom_range(0, 5) == 0);
      end
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk); #1;
      end
    end
    check_stats("rand");
    drain("rand");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
